full_subtractor: RTL and testbench

Registered ripple-borrow subtractor computing d = a - b - Bin with borrow-out Bout. WIDTH=1 gives the classic 1-bit full subtractor. Used as a leaf arithmetic block in datapaths needing a clean, one-cycle, valid-qualified subtract. Built from a chain of 1-bit combinational subtractor cells feeding an output register stage.

---
 rtl/full_subtractor_pkg.sv | 19 +
 rtl/full_subtractor_cell.sv | 18 +
 rtl/full_subtractor.sv | 67 ++++++
 tb/tb_full_subtractor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/full_subtractor_pkg.sv
// rtl/full_subtractor_pkg.sv - shared constants, cell result type and bit-subtract helper for full_subtractor
package full_subtractor_pkg;

    localparam int FS_MAX_WIDTH = 64;

    typedef struct packed {
        logic d;
        logic bout;
    } fs_bit_res_t;

    // One borrow-ripple step: difference bit and borrow into the next-higher bit
    function automatic fs_bit_res_t fs_bit_sub(input logic a, input logic b, input logic bin);
        fs_bit_res_t r;
        r.d    = a ^ b ^ bin;
        r.bout = (~a & b) | (~(a ^ b) & bin);
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// rtl/full_subtractor_cell.sv - combinational 1-bit full subtractor cell
module full_subtractor_cell
    import full_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    fs_bit_res_t res;

    assign res  = fs_bit_sub(a, b, bin);
    assign d    = res.d;
    assign bout = res.bout;

endmodule

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - registered ripple-borrow subtractor d = a - b - Bin; FULL_SUBTRACTOR_OVF_EN adds ovf
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Bin,
    output logic [WIDTH-1:0] d,
    output logic             Bout,
    output logic             out_valid
`ifdef FULL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (WIDTH < 1 || WIDTH > FS_MAX_WIDTH) begin : g_width_check
        $error("full_subtractor: WIDTH out of range");
    end

    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] diff;

    assign br[0] = Bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_subtractor_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (br[i]),
            .d    (diff[i]),
            .bout (br[i+1])
        );
    end

`ifdef FULL_SUBTRACTOR_OVF_EN
    logic ovf_next;
    assign ovf_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
`endif

    // Result registers load only on in_valid, so idle-cycle operands never reach d/Bout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d         <= '0;
            Bout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef FULL_SUBTRACTOR_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d    <= diff;
                Bout <= br[WIDTH];
`ifdef FULL_SUBTRACTOR_OVF_EN
                ovf  <= ovf_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_full_subtractor.sv
// tb/tb_full_subtractor.sv - directed self-checking bench for full_subtractor (WIDTH=1 and WIDTH=8 instances)
module tb_full_subtractor;

    logic       clk;
    logic       rst;
    logic       v1, a1, b1, bin1;
    logic       d1, bo1, ov1;
    logic       v8, bin8;
    logic [7:0] a8, b8;
    logic [7:0] d8;
    logic       bo8, ov8;
`ifdef FULL_SUBTRACTOR_OVF_EN
    logic       ovf1, ovf8;
`endif

    int tests;
    int fails;

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .Bin       (bin1),
        .d         (d1),
        .Bout      (bo1),
        .out_valid (ov1)
`ifdef FULL_SUBTRACTOR_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .Bin       (bin8),
        .d         (d8),
        .Bout      (bo8),
        .out_valid (ov8)
`ifdef FULL_SUBTRACTOR_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        v1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        v8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        @(negedge clk);
        tests++;
        if ({ov1, bo1, d1} !== 3'b000) begin
            fails++;
            $display("FAIL reset_w1: got ov/bout/d=%b expected 000", {ov1, bo1, d1});
        end
        tests++;
        if ({ov8, bo8, d8} !== 10'h000) begin
            fails++;
            $display("FAIL reset_w8: got ov/bout/d=%h expected 000", {ov8, bo8, d8});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exhaustive_w1();
        // index = {a,b,Bin}; bit i holds the expected output for that index
        logic [7:0] exp_d_tab;
        logic [7:0] exp_b_tab;
        logic [2:0] idx;
        exp_d_tab = 8'b1001_0110;
        exp_b_tab = 8'b1000_1110;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests++;
                if ({ov1, bo1, d1} !== {1'b1, exp_b_tab[idx], exp_d_tab[idx]}) begin
                    fails++;
                    $display("FAIL w1_truth[%0d]: got ov/bout/d=%b expected %b", idx,
                             {ov1, bo1, d1}, {1'b1, exp_b_tab[idx], exp_d_tab[idx]});
                end
            end
            if (i < 8) begin
                idx = i[2:0];
                {a1, b1, bin1} = idx;
                v1 = 1'b1;
            end else begin
                v1 = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a1 = 1; b1 = 0; bin1 = 0; v1 = 1;
        @(posedge clk);
        #2;
        tests++;
        if ({ov1, bo1, d1} !== 3'b101) begin
            fails++;
            $display("FAIL async_pre: got ov/bout/d=%b expected 101", {ov1, bo1, d1});
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({ov1, bo1, d1} !== 3'b000) begin
            fails++;
            $display("FAIL async_rst: got ov/bout/d=%b expected 000", {ov1, bo1, d1});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({ov1, bo1, d1} !== 3'b101) begin
            fails++;
            $display("FAIL post_release: got ov/bout/d=%b expected 101", {ov1, bo1, d1});
        end
        v1 = 0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        a1 = 1; b1 = 1; bin1 = 1; v1 = 1;
        @(negedge clk);
        tests++;
        if ({ov1, bo1, d1} !== 3'b111) begin
            fails++;
            $display("FAIL hold_load: got ov/bout/d=%b expected 111", {ov1, bo1, d1});
        end
        v1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({ov1, bo1, d1} !== 3'b011) begin
                fails++;
                $display("FAIL hold[%0d]: got ov/bout/d=%b expected 011", i, {ov1, bo1, d1});
            end
            a1 = ~a1; b1 = i[0]; bin1 = ~bin1;
        end
    endtask

    task automatic test_wrap_w8();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic       vbin [4];
        logic [7:0] ed [4];
        logic       eb [4];
        va[0] = 8'h00; vb[0] = 8'h01; vbin[0] = 0; ed[0] = 8'hFF; eb[0] = 1;
        va[1] = 8'h80; vb[1] = 8'h7F; vbin[1] = 1; ed[1] = 8'h00; eb[1] = 0;
        va[2] = 8'hFF; vb[2] = 8'hFF; vbin[2] = 1; ed[2] = 8'hFF; eb[2] = 1;
        va[3] = 8'hFF; vb[3] = 8'h00; vbin[3] = 0; ed[3] = 8'hFF; eb[3] = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a8 = va[i]; b8 = vb[i]; bin8 = vbin[i]; v8 = 1;
            @(negedge clk);
            v8 = 0;
            tests++;
            if ({ov8, bo8, d8} !== {1'b1, eb[i], ed[i]}) begin
                fails++;
                $display("FAIL wrap_w8[%0d]: got ov=%b bout=%b d=%h expected ov=1 bout=%b d=%h",
                         i, ov8, bo8, d8, eb[i], ed[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] full;
        logic [7:0] exp_d;
        logic       exp_b;
        logic       exp_v;
`ifdef FULL_SUBTRACTOR_OVF_EN
        logic       exp_o;
        exp_o = 1'b0;
`endif
        // Prior state from test_wrap_w8's last op: 0xFF - 0x00 - 0
        exp_d = 8'hFF; exp_b = 1'b0; exp_v = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            tests++;
            if (ov8 !== exp_v) begin
                fails++;
                $display("FAIL b2b_valid[%0d]: got %b expected %b", i, ov8, exp_v);
            end
            tests++;
            if ({bo8, d8} !== {exp_b, exp_d}) begin
                fails++;
                $display("FAIL b2b_data[%0d]: got bout=%b d=%h expected bout=%b d=%h",
                         i, bo8, d8, exp_b, exp_d);
            end
`ifdef FULL_SUBTRACTOR_OVF_EN
            tests++;
            if (ovf8 !== exp_o) begin
                fails++;
                $display("FAIL b2b_ovf[%0d]: got %b expected %b", i, ovf8, exp_o);
            end
`endif
            if (i < 100) begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                bin8 = 1'($urandom);
                v8   = (i < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else begin
                v8 = 1'b0;
            end
            exp_v = v8;
            if (v8) begin
                full  = {1'b0, a8} - {1'b0, b8} - {8'h00, bin8};
                exp_d = full[7:0];
                exp_b = full[8];
`ifdef FULL_SUBTRACTOR_OVF_EN
                exp_o = (a8[7] != b8[7]) && (full[7] != a8[7]);
`endif
            end
        end
    endtask

`ifdef FULL_SUBTRACTOR_OVF_EN
    task automatic test_ovf();
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; bin8 = 0; v8 = 1;
        @(negedge clk);
        tests++;
        if ({ovf8, d8} !== {1'b1, 8'h7F}) begin
            fails++;
            $display("FAIL ovf_set: got ovf=%b d=%h expected ovf=1 d=7f", ovf8, d8);
        end
        a8 = 8'h05; b8 = 8'h03; bin8 = 0; v8 = 1;
        @(negedge clk);
        v8 = 0;
        tests++;
        if ({ovf8, d8} !== {1'b0, 8'h02}) begin
            fails++;
            $display("FAIL ovf_clear: got ovf=%b d=%h expected ovf=0 d=02", ovf8, d8);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_exhaustive_w1();
        test_async_reset();
        test_hold();
        test_wrap_w8();
        test_back_to_back();
`ifdef FULL_SUBTRACTOR_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
